// File: rtl/bcd_8421_conv.sv
// ---------------------------------------------------------------------------
// bcd_8421_conv
//
// Purpose:
//    Continuously converts a 20-bit unsigned binary value into six 4-bit
//    8421-BCD digits for the 7-segment / 595 dynamic scan driver. A sequential
//    shift-and-add-3 (double-dabble) engine runs in a fixed 22-cycle frame:
//       cnt == 0      : sample data into the shift register
//       cnt == 1..20  : one add-3 correction plus one left shift per cycle
//       cnt == 21     : publish the six digits on the outputs
//    The outputs hold the last completed result for the whole next frame.
//
// Parameters:
//    DATA_W   binary input width; the digit count is fixed at 6, so this
//             must stay at 20
//
// Ports:
//    sys_clk  in   1   system clock, all logic on the rising edge
//    sys_rst  in   1   synchronous, active-high reset
//    data     in   20  unsigned binary value to convert
//    unit     out  4   BCD digit 10^0
//    ten      out  4   BCD digit 10^1
//    hun      out  4   BCD digit 10^2
//    tho      out  4   BCD digit 10^3
//    t_tho    out  4   BCD digit 10^4
//    h_tho    out  4   BCD digit 10^5
//    ovf      out  1   only with BCD_8421_OVF_EN defined
//
// Build option:
//    BCD_8421_OVF_EN  when defined, inputs above 999_999 raise ovf and the
//                     digits saturate to 999999. When undefined there is no
//                     ovf port and the outputs show data mod 1_000_000.
// ---------------------------------------------------------------------------
module bcd_8421_conv #(
   parameter int DATA_W = 20
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [DATA_W-1:0] data,
   output logic [3:0]        unit,
   output logic [3:0]        ten,
   output logic [3:0]        hun,
   output logic [3:0]        tho,
   output logic [3:0]        t_tho,
   output logic [3:0]        h_tho
`ifdef BCD_8421_OVF_EN
   ,
   output logic              ovf
`endif
);

   localparam int         DIGITS   = 6;
   localparam int         BCD_W    = 4 * DIGITS;
   localparam int         SR_W     = BCD_W + DATA_W;
   localparam logic [4:0] CNT_LOAD = 5'd0;
   localparam logic [4:0] CNT_LAST = 5'd21;

`ifdef BCD_8421_OVF_EN
   localparam logic [DATA_W-1:0] MAX_VAL = DATA_W'(999_999);
`endif

   // Frame phases decoded from the cycle counter
   typedef enum logic [1:0] {
      PH_LOAD,
      PH_SHIFT,
      PH_LATCH
   } phase_t;

   logic [4:0]      cnt;
   logic [SR_W-1:0] sr;
   phase_t          phase;
   logic [BCD_W-1:0] bcd_adj;
   logic [SR_W-1:0] sr_step;
   logic [BCD_W-1:0] result;

`ifdef BCD_8421_OVF_EN
   logic ovf_pend;
`endif

   // Double-dabble correction: a nibble of 5 or more would become 10 or
   // more after the next doubling, so pre-add 3 to make the carry land in
   // the next digit instead.
   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? (d + 4'd3) : d;
   endfunction

   // Decode the counter into a phase. Any out-of-range count is treated as
   // a shift cycle; the counter itself forces it back to the load phase on
   // the next edge.
   always_comb begin
      phase = PH_SHIFT;
      if (cnt == CNT_LOAD) begin
         phase = PH_LOAD;
      end else if (cnt == CNT_LAST) begin
         phase = PH_LATCH;
      end
   end

   // One combined conversion step: correct every BCD nibble, then shift the
   // whole {bcd, bin} register left by one. The bit leaving the top nibble
   // is the discarded 10^6 digit, which is what gives modulo behaviour.
   always_comb begin
      bcd_adj = '0;
      for (int i = 0; i < DIGITS; i++) begin
         bcd_adj[4*i +: 4] = add3(sr[DATA_W + 4*i +: 4]);
      end
      sr_step = {bcd_adj, sr[DATA_W-1:0]} << 1;
   end

   // Value presented to the output registers at the end of the frame.
   // With the overflow option an oversized sample saturates to all nines.
   always_comb begin
      result = sr[SR_W-1:DATA_W];
`ifdef BCD_8421_OVF_EN
      if (ovf_pend) begin
         result = {DIGITS{4'd9}};
      end
`endif
   end

   // Frame sequencer, conversion register and registered outputs. The
   // counter never stalls, so a reset mid-frame simply restarts the frame
   // from the load phase with cleared outputs.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         cnt   <= CNT_LOAD;
         sr    <= '0;
         unit  <= '0;
         ten   <= '0;
         hun   <= '0;
         tho   <= '0;
         t_tho <= '0;
         h_tho <= '0;
`ifdef BCD_8421_OVF_EN
         ovf      <= 1'b0;
         ovf_pend <= 1'b0;
`endif
      end else begin
         cnt <= (cnt >= CNT_LAST) ? CNT_LOAD : (cnt + 5'd1);
         case (phase)
            PH_LOAD: begin
               sr <= {{BCD_W{1'b0}}, data};
`ifdef BCD_8421_OVF_EN
               ovf_pend <= (data > MAX_VAL);
`endif
            end
            PH_SHIFT: begin
               sr <= sr_step;
            end
            PH_LATCH: begin
               h_tho <= result[23:20];
               t_tho <= result[19:16];
               tho   <= result[15:12];
               hun   <= result[11:8];
               ten   <= result[7:4];
               unit  <= result[3:0];
`ifdef BCD_8421_OVF_EN
               ovf   <= ovf_pend;
`endif
            end
            default: begin
               sr <= sr;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_8421_conv.sv
// ---------------------------------------------------------------------------
// tb_bcd_8421_conv
//
// Purpose:
//    Self-checking bench for bcd_8421_conv. A frame-level reference model
//    (sample at the start of each 22-cycle frame, show it at the end, digits
//    computed with plain decimal arithmetic) is compared against the DUT on
//    every falling edge. On top of that, a vector table and hand-written
//    sequences check reset, latency, mid-frame changes and overflow.
//
// Build option:
//    BCD_8421_OVF_EN  enables the ovf port and saturating expectations
// ---------------------------------------------------------------------------
module tb_bcd_8421_conv;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic [19:0] data;
   logic [3:0]  unit, ten, hun, tho, t_tho, h_tho;
`ifdef BCD_8421_OVF_EN
   logic        ovf;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [19:0] din;
      logic [24:0] expect_word;
   } vec_t;

   vec_t vecs[8];

   // Free-running clock, 10 time units per cycle
   always #5 sys_clk = ~sys_clk;

   bcd_8421_conv #(
      .DATA_W(20)
   ) dut (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .data   (data),
      .unit   (unit),
      .ten    (ten),
      .hun    (hun),
      .tho    (tho),
      .t_tho  (t_tho),
      .h_tho  (h_tho)
`ifdef BCD_8421_OVF_EN
      ,
      .ovf    (ovf)
`endif
   );

   // DUT outputs gathered as {ovf, h_tho..unit}
   logic [24:0] dut_word;
`ifdef BCD_8421_OVF_EN
   assign dut_word = {ovf, h_tho, t_tho, tho, hun, ten, unit};
`else
   assign dut_word = {1'b0, h_tho, t_tho, tho, hun, ten, unit};
`endif

   // Reference conversion: decimal digits from division and remainder,
   // saturating or wrapping depending on the build option.
   function automatic logic [24:0] ref_word(input int unsigned v);
      logic [24:0]  w;
      int unsigned  r;
      int unsigned  p;
      w = '0;
`ifdef BCD_8421_OVF_EN
      if (v > 999_999) begin
         return {1'b1, 24'h999999};
      end
`endif
      r = v % 1_000_000;
      p = 1;
      for (int i = 0; i < 6; i++) begin
         w[4*i +: 4] = 4'((r / p) % 10);
         p = p * 10;
      end
      return w;
   endfunction

   // Frame-level reference: ph is the frame position the next edge acts on
   int unsigned ph = 0;
   int unsigned pend = 0;
   int unsigned shown = 0;
   bit          model_valid = 1'b0;

   always @(posedge sys_clk) begin
      if (sys_rst) begin
         ph          = 0;
         shown       = 0;
         model_valid = 1'b1;
      end else if (model_valid) begin
         if (ph == 0) pend = data;
         if (ph == 21) shown = pend;
         ph = (ph == 21) ? 0 : ph + 1;
      end
   end

   // Compare one value and report any difference
   task automatic checkOutput(input string name, input logic [24:0] act,
                              input logic [24:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s got ovf=%b digits=%h want ovf=%b digits=%h",
                  name, act[24], act[23:0], req[24], req[23:0]);
      end
   endtask

   // Continuous comparison against the reference model
   always @(negedge sys_clk) begin
      if (model_valid) begin
         checkOutput("model", dut_word, ref_word(shown));
      end
   end

   // Drive a new input value away from the active edge
   task automatic applyStimulus(input logic [19:0] v);
      @(negedge sys_clk);
      data = v;
   endtask

   // Advance falling edges until the next active edge acts on frame
   // position t; a missed target is counted as a failure
   task automatic waitPhase(input int unsigned t);
      int n;
      n = 0;
      while (ph != t && n < 40) begin
         @(negedge sys_clk);
         n++;
      end
      if (ph != t) begin
         checks++;
         errors++;
         $display("[TB] FAIL phase_wait got %0d want %0d", ph, t);
      end
   endtask

   // Step just past the next output-latch edge
   task automatic frameEdge();
      waitPhase(21);
      @(negedge sys_clk);
   endtask

   // Release reset with value v applied; outputs stay zero for 21 edges
   // and show v on the 22nd
   task automatic releaseCheck(input logic [19:0] v, input string name);
      data    = v;
      sys_rst = 1'b0;
      for (int e = 1; e <= 22; e++) begin
         @(negedge sys_clk);
         if (e == 21) checkOutput({name, "_pre"}, dut_word, 25'd0);
         if (e == 22) checkOutput({name, "_first"}, dut_word, ref_word(v));
      end
   endtask

   initial begin
      vecs[0] = '{20'd0,       {1'b0, 24'h000000}};
      vecs[1] = '{20'd999_999, {1'b0, 24'h999999}};
      vecs[2] = '{20'd100_000, {1'b0, 24'h100000}};
      vecs[3] = '{20'd123_456, {1'b0, 24'h123456}};
      vecs[4] = '{20'd500_005, {1'b0, 24'h500005}};
`ifdef BCD_8421_OVF_EN
      vecs[5] = '{20'd1_048_575, {1'b1, 24'h999999}};
`else
      vecs[5] = '{20'd1_048_575, {1'b0, 24'h048575}};
`endif
      vecs[6] = '{20'd42,      {1'b0, 24'h000042}};
      vecs[7] = '{20'd1_000_000, (`ifdef BCD_8421_OVF_EN {1'b1, 24'h999999} `else {1'b0, 24'h000000} `endif)};

      // Reset held with a live input value; outputs must read zero
      sys_rst = 1'b1;
      data    = 20'd0;
      repeat (3) @(negedge sys_clk);
      checkOutput("reset_state", dut_word, 25'd0);

      // First result after reset release
      releaseCheck(20'd123_456, "first_result");

      // Mid-frame change: the old value holds for one more frame
      waitPhase(5);
      data = 20'd654_321;
      frameEdge();
      checkOutput("midframe_hold", dut_word, {1'b0, 24'h123456});
      frameEdge();
      checkOutput("midframe_new", dut_word, {1'b0, 24'h654321});
      applyStimulus(20'd987_654);
      frameEdge();
      frameEdge();
      checkOutput("second_update", dut_word, {1'b0, 24'h987654});

      // Vector table: hold each value for two full frames
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].din);
         frameEdge();
         frameEdge();
         checkOutput($sformatf("vec%0d", i), dut_word, vecs[i].expect_word);
      end

      // Overflow clears again when a small value follows
      applyStimulus(20'd1_048_575);
      frameEdge();
      frameEdge();
      applyStimulus(20'd42);
      frameEdge();
      frameEdge();
      checkOutput("ovf_clear", dut_word, {1'b0, 24'h000042});

      // Reset for one cycle at frame position 10
      waitPhase(10);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      checkOutput("midframe_reset", dut_word, 25'd0);
      releaseCheck(20'd314_159, "after_reset");

      // Random sweep, each value held for one frame length
      for (int i = 0; i < 1000; i++) begin
         applyStimulus(20'($urandom_range(0, 999_999)));
         repeat (21) @(negedge sys_clk);
      end
      frameEdge();
      frameEdge();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
